// File: rtl/rv32i_regfile_gen.sv
// rv32i_regfile_gen: parametrised RV32I/RV32E integer register file with two
// registered-address read ports, one write port, write-first bypass and a clear sequencer.
module rv32i_regfile_gen #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 5,
    parameter bit BYPASS         = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce_read,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [XLEN-1:0]   i_rd,
    input  logic              i_wr,
    output logic [XLEN-1:0]   o_rs1,
    output logic [XLEN-1:0]   o_rs2,
    output logic              o_ready
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                NUM_RD    = 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [ADDR_W-1:0] clr_cnt_next;
    logic              run;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;

    logic [XLEN-1:0]   regs_reg [DEPTH];

    assign run     = (state_reg == ST_RUN);
    assign o_ready = run;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_reg <= ADDR_W'(1);
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // The clear sequencer and the architectural write share the single write port.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        wr_en        = 1'b0;
        wr_addr      = i_rd_addr;
        wr_data      = i_rd;
        case (state_reg)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt_reg;
                wr_data = '0;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                end else begin
                    clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                wr_en = i_wr && (i_rd_addr != '0);
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Writes are held off while reset is asserted so retained contents survive it.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_en) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr_in;
            logic [ADDR_W-1:0] rs_addr_reg;
            logic [XLEN-1:0]   data_out;

            assign addr_in = (gi == 0) ? i_rs1_addr : i_rs2_addr;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    rs_addr_reg <= '0;
                end else if (run && i_ce_read) begin
                    rs_addr_reg <= addr_in;
                end
            end

            // x0 and the whole clear phase read as zero; a same-cycle write wins when bypassing.
            always_comb begin
                if (!run || (rs_addr_reg == '0)) begin
                    data_out = '0;
                end else if (BYPASS && i_wr && (i_rd_addr == rs_addr_reg)) begin
                    data_out = i_rd;
                end else begin
                    data_out = regs_reg[rs_addr_reg];
                end
            end
        end
    endgenerate

    assign o_rs1 = g_rd[0].data_out;
    assign o_rs2 = g_rd[1].data_out;

endmodule

// File: tb/tb_rv32i_regfile_gen.sv
// Self-checking bench for rv32i_regfile_gen: three configurations (RV32I bypass,
// RV32I no bypass, RV32E retain) share stimulus and are compared against a reference model.
module tb_rv32i_regfile_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ce;
    logic        wr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd_addr;
    logic [31:0] rd;

    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2, e_rs1, e_rs2;
    logic        a_rdy, b_rdy, e_rdy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    rv32i_regfile_gen #(.XLEN(32), .ADDR_W(5), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_read(ce),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd_addr),
        .i_rd(rd), .i_wr(wr), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_ready(a_rdy)
    );

    rv32i_regfile_gen #(.XLEN(32), .ADDR_W(5), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_read(ce),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd_addr),
        .i_rd(rd), .i_wr(wr), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_ready(b_rdy)
    );

    rv32i_regfile_gen #(.XLEN(32), .ADDR_W(4), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b0)) dut_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_read(ce),
        .i_rs1_addr(rs1[3:0]), .i_rs2_addr(rs2[3:0]), .i_rd_addr(rd_addr[3:0]),
        .i_rd(rd), .i_wr(wr), .o_rs1(e_rs1), .o_rs2(e_rs2), .o_ready(e_rdy)
    );

    // Reference model: index 0 = dut_a, 1 = dut_b, 2 = dut_e.
    logic [31:0] m_mem   [3][32];
    bit          m_known [3][32];
    int          m_clear_left [3];
    logic [4:0]  m_rs    [3][2];
    bit          m_valid = 1'b0;

    function automatic int cfg_depth(int k);  return (k == 2) ? 16 : 32; endfunction
    function automatic bit cfg_bypass(int k); return (k != 1);           endfunction
    function automatic bit cfg_clear(int k);  return (k != 2);           endfunction

    function automatic logic [4:0] amask(int k, logic [4:0] a);
        return a & 5'(cfg_depth(k) - 1);
    endfunction

    function automatic bit m_out_known(int k, logic [4:0] q);
        if (m_clear_left[k] > 0 || q == 0) return 1'b1;
        if (cfg_bypass(k) && wr && amask(k, rd_addr) == q) return 1'b1;
        return m_known[k][q];
    endfunction

    function automatic logic [31:0] m_out(int k, logic [4:0] q);
        if (m_clear_left[k] > 0 || q == 0) return 32'h0;
        if (cfg_bypass(k) && wr && amask(k, rd_addr) == q) return rd;
        return m_mem[k][q];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_rs[k][0] = 5'd0;
                m_rs[k][1] = 5'd0;
                if (cfg_clear(k)) begin
                    m_clear_left[k] = cfg_depth(k) - 1;
                    for (int j = 0; j < 32; j++) begin
                        m_mem[k][j]   = 32'h0;
                        m_known[k][j] = 1'b1;
                    end
                end else begin
                    m_clear_left[k] = 0;
                end
            end else if (m_clear_left[k] > 0) begin
                m_clear_left[k]--;
            end else begin
                if (wr && amask(k, rd_addr) != 0) begin
                    m_mem[k][amask(k, rd_addr)]   = rd;
                    m_known[k][amask(k, rd_addr)] = 1'b1;
                end
                if (ce) begin
                    m_rs[k][0] = amask(k, rs1);
                    m_rs[k][1] = amask(k, rs2);
                end
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model(int k, string tag, logic [31:0] o1, logic [31:0] o2, logic rdy);
        check($sformatf("%s_ready%0d", tag, k), {31'b0, rdy}, {31'b0, m_clear_left[k] == 0});
        if (m_out_known(k, m_rs[k][0])) check($sformatf("%s_rs1_%0d", tag, k), o1, m_out(k, m_rs[k][0]));
        if (m_out_known(k, m_rs[k][1])) check($sformatf("%s_rs2_%0d", tag, k), o2, m_out(k, m_rs[k][1]));
    endtask

    // Inputs are driven just after a falling edge; outputs are sampled 1 ns later.
    task automatic step(string tag);
        #1;
        $display("cyc=%0d %s rst_n=%0b wr=%0b rd[%0d]=%h ce=%0b rs=%0d/%0d a=%h/%h b=%h/%h e=%h/%h rdy=%0b%0b%0b",
                 cyc, tag, rst_n, wr, rd_addr, rd, ce, rs1, rs2,
                 a_rs1, a_rs2, b_rs1, b_rs2, e_rs1, e_rs2, a_rdy, b_rdy, e_rdy);
        if (m_valid && rst_n) begin
            check_model(0, tag, a_rs1, a_rs2, a_rdy);
            check_model(1, tag, b_rs1, b_rs2, b_rdy);
            check_model(2, tag, e_rs1, e_rs2, e_rdy);
        end
        @(posedge clk);
        model_edge();
        if (!rst_n) m_valid = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic count_clear(string name);
        int n = 0;
        while (!a_rdy && n < 100) begin
            step("clr");
            n++;
        end
        check(name, 32'(n), 32'd31);
    endtask

    typedef struct {
        bit        wr;
        bit [4:0]  rd_addr;
        bit [31:0] rd;
        bit        ce;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [31:0] a1, a2, b1, b2;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 32; j++) m_known[k][j] = 1'b0;
        for (int k = 0; k < 3; k++) m_clear_left[k] = 0;

        //            wr    rd_addr rd            ce    rs1   rs2   a1            a2            b1            b2
        tbl[0]  = '{1'b1, 5'd1, 32'h12345678, 1'b1, 5'd1, 5'd2, 32'h0,        32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b1, 5'd2, 32'hCAFEF00D, 1'b0, 5'd1, 5'd2, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'h02020202};
        tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd2, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
        tbl[4]  = '{1'b1, 5'd7, 32'h00000001, 1'b0, 5'd7, 5'd7, 32'h00000001, 32'h00000001, 32'h07070707, 32'h07070707};
        tbl[5]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000001, 32'h00000001};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[7]  = '{1'b1, 5'd9, 32'h00000011, 1'b1, 5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd9, 32'h00000011, 32'h00000011, 32'h00000011, 32'h00000011};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd1, 32'h00000011, 32'h00000011, 32'h00000011, 32'h00000011};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd1, 32'h0,        32'h12345678, 32'h0,        32'h12345678};

        rst_n = 1'b0; wr = 1'b0; ce = 1'b0; rd_addr = '0; rd = '0; rs1 = '0; rs2 = '0;
        @(negedge clk);
        step("rst");
        step("rst");
        rst_n = 1'b1;
        #1;
        check("a_ready_after_reset", {31'b0, a_rdy}, 32'd0);
        check("e_ready_after_reset", {31'b0, e_rdy}, 32'd1);
        check("a_rs1_after_reset", a_rs1, 32'h0);
        count_clear("clear_edges_initial");

        for (int i = 1; i < 32; i++) begin
            wr = 1'b1; rd_addr = 5'(i); rd = 32'(i) * 32'h01010101; ce = 1'b0;
            step("init");
        end
        wr = 1'b0; ce = 1'b1; rs1 = '0; rs2 = '0;
        step("setup");

        for (int i = 0; i < 11; i++) begin
            wr = tbl[i].wr; rd_addr = tbl[i].rd_addr; rd = tbl[i].rd;
            ce = tbl[i].ce; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
            #1;
            check($sformatf("tbl%0d_a_rs1", i), a_rs1, tbl[i].a1);
            check($sformatf("tbl%0d_a_rs2", i), a_rs2, tbl[i].a2);
            check($sformatf("tbl%0d_b_rs1", i), b_rs1, tbl[i].b1);
            check($sformatf("tbl%0d_b_rs2", i), b_rs2, tbl[i].b2);
            step("tbl");
        end

        // Reset clear with a locked-out write during CLEAR; dut_e keeps running and retains.
        wr = 1'b1; rd_addr = 5'd5; rd = 32'hDEADBEEF; ce = 1'b0;
        step("pre");
        wr = 1'b0; rst_n = 1'b0;
        step("rst");
        rst_n = 1'b1;
        wr = 1'b1; rd_addr = 5'd3; rd = 32'h55; ce = 1'b1; rs1 = 5'd5; rs2 = 5'd3;
        count_clear("clear_edges_rerun");
        wr = 1'b0; ce = 1'b1; rs1 = 5'd5; rs2 = 5'd3;
        step("rd");
        ce = 1'b0;
        #1;
        check("a_x5_cleared", a_rs1, 32'h0);
        check("a_x3_lockout", a_rs2, 32'h0);
        check("e_x5_retained", e_rs1, 32'hDEADBEEF);
        check("e_x3_written", e_rs2, 32'h55);
        step("rd");

        // Reset in the middle of CLEAR restarts the full sequence.
        rst_n = 1'b0;
        step("rst");
        rst_n = 1'b1;
        repeat (10) step("clr");
        rst_n = 1'b0;
        step("rst");
        rst_n = 1'b1;
        count_clear("clear_edges_restart");

        wr = 1'b1; rd_addr = 5'd15; rd = 32'h0F0F0F0F; ce = 1'b1; rs1 = 5'd15; rs2 = 5'd0;
        step("x15");
        wr = 1'b0; ce = 1'b0;
        #1;
        check("e_x15_readback", e_rs1, 32'h0F0F0F0F);
        step("x15");

        for (int i = 0; i < 300; i++) begin
            rst_n   = ($urandom_range(0, 149) != 0);
            wr      = 1'($urandom);
            rd_addr = 5'($urandom);
            rd      = $urandom;
            ce      = 1'($urandom);
            rs1     = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            rs2     = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_regfile_gen.md
# rv32i_regfile_gen

Parametrised integer register file for the DECODE/WRITEBACK stages: two synchronous-address read ports gated by the decode-stage clock enable and one write port. Register 0 is hardwired to zero. Compared with the fixed 32×32 base register file, it adds:
- configurable width and depth (RV32I/RV32E);
- a write-first bypass for same-cycle read/write collisions;
- a reset-driven clear sequencer with a ready flag, so contents are defined after any reset, not only at power-up.

## Interface
- XLEN, 32, register data width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W (5 → 32 regs RV32I, 4 → 16 regs RV32E).
- BYPASS, 1, 1 = forward same-cycle write data to matching read port; 0 = array value only.
- CLEAR_ON_RESET, 1, 1 = zero registers 1..DEPTH-1 after reset; 0 = contents retained across reset.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_ce_read  in  1  decode-stage enable; captures read addresses.
- i_rs1_addr  in  ADDR_W  source register 1 address.
- i_rs2_addr  in  ADDR_W  source register 2 address.
- i_rd_addr  in  ADDR_W  destination register address.
- i_rd  in  XLEN  write data.
- i_wr  in  1  write enable.
- o_rs1  out  XLEN  source register 1 value.
- o_rs2  out  XLEN  source register 2 value.
- o_ready  out  1  high when in RUN state (clear complete; reads and writes honoured).

## Operation
- States: CLEAR, RUN.
- Reset (i_rst_n low at an edge):
  - state ← CLEAR if CLEAR_ON_RESET = 1, else RUN;
  - clear counter ← 1;
  - rs1/rs2 address registers ← 0.
- CLEAR:
  - Each edge writes 0 to reg[counter], then counter increments.
  - The edge that writes reg[DEPTH-1] moves the state to RUN.
  - i_wr and i_ce_read are ignored.
  - o_rs1 and o_rs2 are forced to 0.
- RUN:
  - Write: if i_wr = 1 and i_rd_addr ≠ 0, reg[i_rd_addr] ← i_rd at the edge. Writes to address 0 are discarded.
  - Read capture: if i_ce_read = 1, rs1_q ← i_rs1_addr and rs2_q ← i_rs2_addr at the edge; otherwise both hold.
- Read output (combinational from rsX_q):
  - 0 if rsX_q = 0;
  - else i_rd if BYPASS = 1, i_wr = 1, i_rd_addr = rsX_q, and state is RUN;
  - else reg[rsX_q].
- Both ports are independent. Identical addresses on both ports are legal.
- The counter is ADDR_W bits. It never wraps, because CLEAR exits at DEPTH-1.

## Timing
- Reset values: o_ready = 0 when CLEAR_ON_RESET = 1, else 1 on the first edge after reset; o_rs1 = o_rs2 = 0.
- Clear duration: DEPTH-1 edges after i_rst_n returns high. o_ready rises after edge DEPTH-1 (31 edges for DEPTH 32, 15 for DEPTH 16).
- Reset asserted mid-CLEAR: clear restarts from register 1.
- Reset asserted in RUN: contents zeroed again (CLEAR_ON_RESET = 1) or retained (CLEAR_ON_RESET = 0).
- Read latency: address sampled at edge N; data is valid combinationally after edge N and stays valid while i_ce_read = 0. A later write to the held address updates the output after its write edge.
- Write latency: array updated at the write edge.
- With BYPASS = 1, the output shows i_rd during the write cycle itself (write-first). With BYPASS = 0, it shows the old value until the edge.
- Simultaneous write and read capture of the same address in one cycle: after the edge the output equals the new value under either BYPASS setting.

## Test plan
- Reset clear: preload x5 = 0xDEADBEEF, pulse i_rst_n low for 1 cycle → o_ready low for exactly 31 edges (ADDR_W = 5). Then read x5 → 0x00000000.
- Basic R/W: write x1 = 0x12345678 and x2 = 0xCAFEF00D; capture rs1 = 1, rs2 = 2 → o_rs1 = 0x12345678, o_rs2 = 0xCAFEF00D.
- x0 protection: write x0 = 0xFFFFFFFF; read rs1 = 0 → 0.
- Bypass: hold rs1_q = 7 with x7 = 0x1. In one cycle drive i_wr = 1, i_rd_addr = 7, i_rd = 0xA5A5A5A5 → o_rs1 = 0xA5A5A5A5 in that cycle with BYPASS = 1, 0x1 with BYPASS = 0. Both settings give 0xA5A5A5A5 after the edge.
- CE hold / CLEAR lockout: with i_ce_read = 0, change i_rs1_addr → o_rs1 is unchanged. With i_wr = 1 during CLEAR to x3 = 0x55 → x3 reads 0 after o_ready rises.
- RV32E config (ADDR_W = 4, CLEAR_ON_RESET = 0):
  - o_ready = 1 on the first edge after reset;
  - write x15 = 0x0F0F0F0F and read it back;
  - contents retained across a second reset.
